// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : WIDTH-bit sequential ALU with integrated Z/N/C/V flag register.
//
// Sits between the instruction sequencer (valid/ready request) and register
// file writeback (valid/ready result). Arithmetic and logic ops take one
// cycle. Shifts by a non-zero amount run one bit per cycle through a working
// register.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   in_valid  in   request valid
//   in_ready  out  unit is idle and can accept a request
//   a, b      in   operands; b[SHAMT_W-1:0] is the shift amount
//   opcode    in   operation select (see localparams)
//   out_valid out  result valid (held until out_ready)
//   out_ready in   consumer accepts result
//   alu_out   out  registered result
//   zero, negative, carry, overflow  out  registered flags
//   busy      out  high while shifting or holding a result
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADC = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_CMP = 4'b1011;

  // Low two opcode bits of the shift ops, kept while shifting.
  localparam logic [1:0] SH_LL = 2'b00;
  localparam logic [1:0] SH_RL = 2'b01;
  localparam logic [1:0] SH_RA = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // Full adder over WIDTH bits; MSB of the return value is the carry out.
  // Subtraction is done as x + ~y + cin so carry out means "no borrow".
  function automatic logic [WIDTH:0] add_c(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic             cin);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  endfunction

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic ovf(input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y,
                               input logic [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_alu_out, w_alu_out_nxt;
  logic                 r_z, r_n, r_c, r_v;
  logic                 w_z_nxt, w_n_nxt, w_c_nxt, w_v_nxt;
  logic [WIDTH-1:0]     r_work, w_work_nxt;
  logic [SHAMT_W-1:0]   r_count, w_count_nxt;
  logic [1:0]           r_sh_op, w_sh_op_nxt;

  // Single-cycle ALU results
  logic [SHAMT_W-1:0]   w_shamt;
  logic                 w_is_shift;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_res;       // value for alu_out
  logic [WIDTH-1:0]     w_flag_val;  // value Z/N are derived from
  logic                 w_res_c, w_res_v;
  logic                 w_wr_res, w_wr_flags;

  // Shift step results
  logic [WIDTH-1:0]     w_sh_val;
  logic                 w_sh_bit;

  assign w_shamt    = b[SHAMT_W-1:0];
  assign w_is_shift = (opcode == OP_SLL) || (opcode == OP_SRL) || (opcode == OP_SRA);

  // Combinational ALU for the ops finished at the accept edge.
  always_comb begin
    w_sum      = '0;
    w_res      = '0;
    w_flag_val = '0;
    w_res_c    = 1'b0;
    w_res_v    = 1'b0;
    w_wr_res   = 1'b1;
    w_wr_flags = 1'b1;
    case (opcode)
      OP_ADD: begin
        w_sum   = add_c(a, b, 1'b0);
        w_res   = w_sum[WIDTH-1:0];
        w_res_c = w_sum[WIDTH];
        w_res_v = ovf(a, b, w_sum[WIDTH-1:0]);
      end
      OP_SUB, OP_CMP: begin
        w_sum   = add_c(a, ~b, 1'b1);
        w_res   = w_sum[WIDTH-1:0];
        w_res_c = w_sum[WIDTH];
        w_res_v = ovf(a, ~b, w_sum[WIDTH-1:0]);
        // CMP only updates flags; alu_out keeps the previous result.
        if (opcode == OP_CMP) begin
          w_wr_res = 1'b0;
        end else begin
          w_wr_res = 1'b1;
        end
      end
      OP_ADC: begin
        w_sum   = add_c(a, b, r_c);
        w_res   = w_sum[WIDTH-1:0];
        w_res_c = w_sum[WIDTH];
        w_res_v = ovf(a, b, w_sum[WIDTH-1:0]);
      end
      OP_SBC: begin
        // a - b - (1 - C) == a + ~b + C
        w_sum   = add_c(a, ~b, r_c);
        w_res   = w_sum[WIDTH-1:0];
        w_res_c = w_sum[WIDTH];
        w_res_v = ovf(a, ~b, w_sum[WIDTH-1:0]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      // Only reached here with a zero shift amount: pass a through, C=0.
      OP_SLL, OP_SRL, OP_SRA: w_res = a;
      default: begin
        // Illegal opcode: clear the result, leave flags alone.
        w_res      = '0;
        w_wr_flags = 1'b0;
      end
    endcase
    w_flag_val = w_res;
  end

  // One-bit shift step of the working register; w_sh_bit is the bit shifted out.
  always_comb begin
    w_sh_val = r_work;
    w_sh_bit = 1'b0;
    case (r_sh_op)
      SH_LL: begin
        w_sh_val = {r_work[WIDTH-2:0], 1'b0};
        w_sh_bit = r_work[WIDTH-1];
      end
      SH_RL: begin
        w_sh_val = {1'b0, r_work[WIDTH-1:1]};
        w_sh_bit = r_work[0];
      end
      SH_RA: begin
        w_sh_val = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
        w_sh_bit = r_work[0];
      end
      default: begin
        w_sh_val = r_work;
        w_sh_bit = 1'b0;
      end
    endcase
  end

  // Next-state and next-register logic of the control FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_alu_out_nxt = r_alu_out;
    w_z_nxt       = r_z;
    w_n_nxt       = r_n;
    w_c_nxt       = r_c;
    w_v_nxt       = r_v;
    w_work_nxt    = r_work;
    w_count_nxt   = r_count;
    w_sh_op_nxt   = r_sh_op;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_is_shift && (w_shamt != '0)) begin
            w_work_nxt  = a;
            w_count_nxt = w_shamt;
            w_sh_op_nxt = opcode[1:0];
            w_state_nxt = S_SHIFT;
          end else begin
            if (w_wr_res) begin
              w_alu_out_nxt = w_res;
            end else begin
              w_alu_out_nxt = r_alu_out;
            end
            if (w_wr_flags) begin
              w_z_nxt = (w_flag_val == '0);
              w_n_nxt = w_flag_val[WIDTH-1];
              w_c_nxt = w_res_c;
              w_v_nxt = w_res_v;
            end else begin
              w_z_nxt = r_z;
              w_n_nxt = r_n;
              w_c_nxt = r_c;
              w_v_nxt = r_v;
            end
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_work_nxt  = w_sh_val;
        w_count_nxt = r_count - SHAMT_W'(1);
        // Last step: publish result and flags together.
        if (r_count == SHAMT_W'(1)) begin
          w_alu_out_nxt = w_sh_val;
          w_z_nxt       = (w_sh_val == '0);
          w_n_nxt       = w_sh_val[WIDTH-1];
          w_c_nxt       = w_sh_bit;
          w_v_nxt       = 1'b0;
          w_state_nxt   = S_DONE;
        end else begin
          w_state_nxt   = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, result, flag and shift registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_alu_out <= '0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_work    <= '0;
      r_count   <= '0;
      r_sh_op   <= 2'b00;
    end else begin
      r_state   <= w_state_nxt;
      r_alu_out <= w_alu_out_nxt;
      r_z       <= w_z_nxt;
      r_n       <= w_n_nxt;
      r_c       <= w_c_nxt;
      r_v       <= w_v_nxt;
      r_work    <= w_work_nxt;
      r_count   <= w_count_nxt;
      r_sh_op   <= w_sh_op_nxt;
    end
  end

  // in_ready is masked by reset so it reads 0 while reset is held.
  assign in_ready  = (r_state == S_IDLE) && reset;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign alu_out   = r_alu_out;
  assign zero      = r_z;
  assign negative  = r_n;
  assign carry     = r_c;
  assign overflow  = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq : self-checking bench for alu_seq (WIDTH=8).
// Table of directed vectors with hand-computed results, plus hand-written
// sequences for backpressure and reset in the middle of a shift.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_out;
  logic       zero, negative, carry, overflow, busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out  (alu_out),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flags; // {Z,N,C,V}
    int         lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] aa,
                              input logic [7:0] bb, input logic [7:0] rr,
                              input logic [3:0] fl, input int lt);
    vec_t v;
    v.op = op; v.a = aa; v.b = bb; v.res = rr; v.flags = fl; v.lat = lt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {zero, negative, carry, overflow};
  endfunction

  // Issue one request, scramble the inputs after the accept edge, and count
  // edges until out_valid is seen (accept edge = 1).
  task automatic run_op(input logic [3:0] op, input logic [7:0] aa,
                        input logic [7:0] bb, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", {31'd0, in_ready}, 32'd1);
    a = aa; b = bb; opcode = op; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~aa; b = ~bb; opcode = 4'hE;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      chk("ready_low_while_busy", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
  endtask

  // Consume the pending result and check the unit returns to idle.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; opcode = 4'h0;

    //            op     a      b      res    ZNCV    lat
    vecs.push_back(mk(4'h0, 8'h7F, 8'h01, 8'h80, 4'b0101, 1)); // ADD overflow
    vecs.push_back(mk(4'h0, 8'hFF, 8'h01, 8'h00, 4'b1010, 1)); // ADD carry out
    vecs.push_back(mk(4'h2, 8'h00, 8'h00, 8'h01, 4'b0000, 1)); // ADC C_in=1
    vecs.push_back(mk(4'h1, 8'h05, 8'h05, 8'h00, 4'b1010, 1)); // SUB equal
    vecs.push_back(mk(4'h3, 8'h10, 8'h01, 8'h0F, 4'b0010, 1)); // SBC C_in=1
    vecs.push_back(mk(4'h1, 8'h05, 8'h05, 8'h00, 4'b1010, 1)); // SUB Z=1
    vecs.push_back(mk(4'hF, 8'h12, 8'h34, 8'h00, 4'b1010, 1)); // illegal
    vecs.push_back(mk(4'h0, 8'h03, 8'h04, 8'h07, 4'b0000, 1)); // ADD
    vecs.push_back(mk(4'hB, 8'h02, 8'h05, 8'h07, 4'b0100, 1)); // CMP keeps out
    vecs.push_back(mk(4'hA, 8'h90, 8'h03, 8'hF2, 4'b0100, 4)); // SRA by 3
    vecs.push_back(mk(4'h8, 8'h81, 8'h01, 8'h02, 4'b0010, 2)); // SLL by 1
    vecs.push_back(mk(4'h4, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1)); // AND
    vecs.push_back(mk(4'h5, 8'h0F, 8'h30, 8'h3F, 4'b0000, 1)); // OR
    vecs.push_back(mk(4'h6, 8'hFF, 8'h0F, 8'hF0, 4'b0100, 1)); // XOR
    vecs.push_back(mk(4'h7, 8'h5A, 8'h00, 8'hA5, 4'b0100, 1)); // NOT
    vecs.push_back(mk(4'h9, 8'h81, 8'h00, 8'h81, 4'b0100, 1)); // SRL by 0
    vecs.push_back(mk(4'h3, 8'h00, 8'h01, 8'hFE, 4'b0100, 1)); // SBC C_in=0
    vecs.push_back(mk(4'h1, 8'h80, 8'h01, 8'h7F, 4'b0011, 1)); // SUB overflow
    vecs.push_back(mk(4'h9, 8'h81, 8'h09, 8'h40, 4'b0010, 2)); // SRL, amt=b[2:0]=1
    vecs.push_back(mk(4'h2, 8'h7F, 8'h00, 8'h80, 4'b0101, 1)); // ADC C_in=1 ovf

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_alu_out", {24'd0, alu_out}, 32'h00);
    chk("rst_flags", {28'd0, flags_now()}, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_alu_out", i), {24'd0, alu_out}, {24'd0, vecs[i].res});
      chk($sformatf("v%0d_flags", i), {28'd0, flags_now()}, {28'd0, vecs[i].flags});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      drain();
    end

    // Backpressure: result held 5 cycles while a new request waits
    run_op(4'h0, 8'h12, 8'h34, lat);
    chk("bp_latency", lat, 1);
    a = 8'h01; b = 8'h01; opcode = 4'h0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_alu_out", {24'd0, alu_out}, 32'h46);
      chk("bp_flags", {28'd0, flags_now()}, 32'h0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_alu_out", {24'd0, alu_out}, 32'h02);
    drain();

    // Leave non-zero result/flags visible before the reset test
    run_op(4'h0, 8'h7F, 8'h01, lat);
    chk("pre_rst_alu_out", {24'd0, alu_out}, 32'h80);
    drain();

    // Reset three edges into SRL 0xFF by 7
    @(negedge clk);
    a = 8'hFF; b = 8'h07; opcode = 4'h9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_shift_busy", {31'd0, busy}, 32'd1);
    chk("mid_shift_out_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("async_rst_alu_out", {24'd0, alu_out}, 32'h00);
    chk("async_rst_flags", {28'd0, flags_now()}, 32'h0);
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_op(4'h0, 8'h03, 8'h04, lat);
    chk("after_rst_latency", lat, 1);
    chk("after_rst_alu_out", {24'd0, alu_out}, 32'h07);
    chk("after_rst_flags", {28'd0, flags_now()}, 32'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
